gba_mem_responder: RTL and testbench



---
 rtl/gba_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_gba_mem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gba_mem_responder.sv
// gba_mem_responder: 32-bit on-chip RAM behind the mux link, byte/half/word lanes; GBA_MEM_INIT_CLEAR_EN zeroes RAM after reset.
// Latency: writes commit at the accept edge; read data is valid 2 cycles after accept, one read per 3 cycles.
// Backpressure: readies are high only in IDLE; a concurrent write wins and blocks the read for that cycle.
module gba_mem_responder #(
   parameter int          DEPTH_WORDS = 8192,
   parameter logic [31:0] OOR_DATA    = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [25:0] mem_addr,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [1:0]  mem_data_width,
   input  logic [31:0] mem_wr_data,
   output logic        mem_rd_ready,
   output logic        mem_wr_ready,
   output logic [31:0] mem_rd_data,
   output logic        mem_rd_valid
);

   localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [24:0] DEPTH_L = 25'(DEPTH_WORDS);

`ifdef GBA_MEM_INIT_CLEAR_EN
   typedef enum logic [1:0] {CLEAR, IDLE, RD_MEM, RD_RESP} state_t;
   localparam state_t RST_STATE = CLEAR;
   logic [AW-1:0] clr_idx;
`else
   typedef enum logic [1:0] {IDLE, RD_MEM, RD_RESP} state_t;
   localparam state_t RST_STATE = IDLE;
`endif

   state_t state, state_nxt;

   logic [31:0]   ram [DEPTH_WORDS];
   logic [31:0]   ram_q;
   logic [23:0]   req_idx;
   logic          req_in_range;
   logic          wr_acc, rd_acc;
   logic          ram_we;
   logic [AW-1:0] ram_widx;
   logic [3:0]    ram_be;
   logic [31:0]   ram_wdat;
   logic [1:0]    cap_width;
   logic [1:0]    cap_lane;
   logic          cap_oor;
   logic [31:0]   rd_src;
   logic [31:0]   rd_extract;

   assign req_idx      = mem_addr[25:2];
   assign req_in_range = {1'b0, req_idx} < DEPTH_L;

   always_comb begin
      state_nxt    = state;
      mem_rd_ready = 1'b0;
      mem_wr_ready = 1'b0;
      mem_rd_valid = 1'b0;
      case (state)
`ifdef GBA_MEM_INIT_CLEAR_EN
         CLEAR: begin
            if (clr_idx == AW'(DEPTH_WORDS - 1))
               state_nxt = IDLE;
         end
`endif
         IDLE: begin
            mem_wr_ready = 1'b1;
            mem_rd_ready = ~mem_wr;
            if (mem_rd && !mem_wr)
               state_nxt = RD_MEM;
         end
         RD_MEM:  state_nxt = RD_RESP;
         RD_RESP: begin
            mem_rd_valid = 1'b1;
            state_nxt    = IDLE;
         end
         default: state_nxt = RST_STATE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= RST_STATE;
      else
         state <= state_nxt;
   end

   assign wr_acc = mem_wr & mem_wr_ready & ~rst;
   assign rd_acc = mem_rd & mem_rd_ready & ~rst;

   // Single write port: lane-steered request writes, or the zero sweep after reset.
   always_comb begin
      ram_we   = wr_acc & req_in_range & (mem_data_width != 2'b00);
      ram_widx = req_idx[AW-1:0];
      ram_be   = 4'b0000;
      ram_wdat = mem_wr_data;
      case (mem_data_width)
         2'b01: begin
            ram_be   = 4'b0001 << mem_addr[1:0];
            ram_wdat = {4{mem_wr_data[7:0]}};
         end
         2'b10: begin
            ram_be   = mem_addr[1] ? 4'b1100 : 4'b0011;
            ram_wdat = {2{mem_wr_data[15:0]}};
         end
         2'b11: ram_be = 4'b1111;
         default: ram_be = 4'b0000;
      endcase
`ifdef GBA_MEM_INIT_CLEAR_EN
      if (state == CLEAR && !rst) begin
         ram_we   = 1'b1;
         ram_widx = clr_idx;
         ram_be   = 4'b1111;
         ram_wdat = 32'h0000_0000;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (ram_be[b])
               ram[ram_widx][8*b +: 8] <= ram_wdat[8*b +: 8];
         end
      end
      if (rd_acc)
         ram_q <= ram[req_idx[AW-1:0]];
   end

`ifdef GBA_MEM_INIT_CLEAR_EN
   always_ff @(posedge clk) begin
      if (rst)
         clr_idx <= '0;
      else if (state == CLEAR)
         clr_idx <= clr_idx + 1'b1;
   end
`endif

   // Out-of-range reads take OOR_DATA from its low end, so no lane shift applies.
   always_comb begin
      rd_src = cap_oor ? OOR_DATA : ram_q;
      if (!cap_oor) begin
         case (cap_width)
            2'b01:   rd_src = ram_q >> {cap_lane, 3'b000};
            2'b10:   rd_src = ram_q >> {cap_lane[1], 4'b0000};
            default: rd_src = ram_q;
         endcase
      end
      case (cap_width)
         2'b01:   rd_extract = {24'h00_0000, rd_src[7:0]};
         2'b10:   rd_extract = {16'h0000, rd_src[15:0]};
         2'b11:   rd_extract = rd_src;
         default: rd_extract = OOR_DATA;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_rd_data <= 32'h0000_0000;
         cap_width   <= 2'b00;
         cap_lane    <= 2'b00;
         cap_oor     <= 1'b0;
      end else begin
         if (rd_acc) begin
            cap_width <= mem_data_width;
            cap_lane  <= mem_addr[1:0];
            cap_oor   <= ~req_in_range;
         end
         if (state == RD_MEM)
            mem_rd_data <= rd_extract;
      end
   end

endmodule

// File: tb/tb_gba_mem_responder.sv
// Bench for gba_mem_responder: byte-addressed reference memory plus per-cycle handshake checker.
module tb_gba_mem_responder;

`ifdef GBA_MEM_INIT_CLEAR_EN
   localparam int DEPTH   = 16;
   localparam int CLR_CYC = 16;
`else
   localparam int DEPTH   = 8192;
   localparam int CLR_CYC = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [25:0] mem_addr = '0;
   logic        mem_rd = 1'b0;
   logic        mem_wr = 1'b0;
   logic [1:0]  mem_data_width = 2'b00;
   logic [31:0] mem_wr_data = '0;
   logic        mem_rd_ready, mem_wr_ready, mem_rd_valid;
   logic [31:0] mem_rd_data;

   always #5 clk = ~clk;

   gba_mem_responder #(.DEPTH_WORDS(DEPTH), .OOR_DATA(32'hFFFF_FFFF)) dut (
      .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_data_width(mem_data_width), .mem_wr_data(mem_wr_data),
      .mem_rd_ready(mem_rd_ready), .mem_wr_ready(mem_wr_ready),
      .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference memory: sparse byte array, little-endian, unwritten bytes read as 0.
   bit [7:0] mbytes [int];

   function automatic logic [7:0] mbyte(input int a);
      if (mbytes.exists(a)) return mbytes[a];
      return 8'h00;
   endfunction

   function automatic bit is_oor(input logic [25:0] a);
      return (int'(a) / 4) >= DEPTH;
   endfunction

   function automatic logic [31:0] model_read(input logic [25:0] a, input logic [1:0] w);
      int ai = int'(a);
      if (w == 2'b00) return 32'hFFFF_FFFF;
      if (w == 2'b01) return is_oor(a) ? 32'h0000_00FF : {24'h0, mbyte(ai)};
      if (w == 2'b10) begin
         int h = ai - (ai % 2);
         return is_oor(a) ? 32'h0000_FFFF : {16'h0, mbyte(h + 1), mbyte(h)};
      end
      begin
         int wb = ai - (ai % 4);
         return is_oor(a) ? 32'hFFFF_FFFF :
                {mbyte(wb + 3), mbyte(wb + 2), mbyte(wb + 1), mbyte(wb)};
      end
   endfunction

   task automatic model_write(input logic [25:0] a, input logic [1:0] w, input logic [31:0] d);
      int ai = int'(a);
      int nb;
      int base;
      if (w == 2'b00 || is_oor(a)) return;
      nb   = (w == 2'b01) ? 1 : (w == 2'b10) ? 2 : 4;
      base = ai - (ai % nb);
      for (int i = 0; i < nb; i++) mbytes[base + i] = d[8*i +: 8];
   endtask

   typedef struct { int due; logic [31:0] dat; } exp_t;
   exp_t        pend[$];
   int          cyc = 0;
   int          rem = CLR_CYC;
   logic [31:0] last_dat = 32'h0;

   // Per-cycle checker: readies, valid and held data against the model.
   initial begin
      logic exp_wr_rdy, exp_rd_rdy, exp_vld;
      exp_t e;
      @(posedge clk);
      forever begin
         @(negedge clk);
         cyc++;
         exp_wr_rdy = (rem == 0);
         exp_rd_rdy = exp_wr_rdy && !mem_wr;
         exp_vld    = (pend.size() > 0) && (pend[0].due == cyc);
         if (exp_vld) last_dat = pend[0].dat;
         chk("cyc_wr_ready", {31'b0, mem_wr_ready}, {31'b0, exp_wr_rdy});
         chk("cyc_rd_ready", {31'b0, mem_rd_ready}, {31'b0, exp_rd_rdy});
         chk("cyc_rd_valid", {31'b0, mem_rd_valid}, {31'b0, exp_vld});
         chk("cyc_rd_data", mem_rd_data, last_dat);
         if (exp_vld) void'(pend.pop_front());
         if (rem > 0) rem--;
         if (rst) begin
            rem      = CLR_CYC;
            last_dat = 32'h0;
            pend.delete();
         end else begin
            if (mem_wr && exp_wr_rdy) model_write(mem_addr, mem_data_width, mem_wr_data);
            if (mem_rd && exp_rd_rdy) begin
               e.due = cyc + 2;
               e.dat = model_read(mem_addr, mem_data_width);
               pend.push_back(e);
               rem = 2;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Driver tasks start and end at posedge+1.
   task automatic wait_valid(input string name, input logic [31:0] lit);
      int  lat = 0;
      bit  found = 0;
      repeat (4) begin
         @(negedge clk);
         lat++;
         if (mem_rd_valid && !found) begin
            found = 1;
            chk(name, mem_rd_data, lit);
            chk({name, "_lat"}, 32'(lat), 32'd2);
         end
      end
      if (!found) chk({name, "_timeout"}, 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic do_write(input logic [25:0] a, input logic [1:0] w, input logic [31:0] d);
      int n = 0;
      mem_wr = 1'b1; mem_addr = a; mem_data_width = w; mem_wr_data = d;
      @(negedge clk);
      while (!mem_wr_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("wr_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      mem_wr = 1'b0;
   endtask

   task automatic do_read(input string name, input logic [25:0] a, input logic [1:0] w,
                          input logic [31:0] lit);
      int n = 0;
      chk({name, "_model"}, model_read(a, w), lit);
      mem_rd = 1'b1; mem_addr = a; mem_data_width = w;
      @(negedge clk);
      while (!mem_rd_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk({name, "_acc_timeout"}, 32'd0, 32'd1);
      @(posedge clk); #1;
      mem_rd = 1'b0; mem_addr = 26'h3FF_FFFF; mem_data_width = 2'b00;
      wait_valid(name, lit);
   endtask

   initial begin
      int n;
      int vcount;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
`ifdef GBA_MEM_INIT_CLEAR_EN
      n = 0;
      @(negedge clk);
      while (!mem_wr_ready && n < 100) begin n++; @(negedge clk); end
      chk("clear_cycles", 32'(n), 32'd16);
      @(posedge clk); #1;
      do_read("clr_w0", 26'h008, 2'b11, 32'h0000_0000);
      do_read("clr_w15", 26'h03C, 2'b11, 32'h0000_0000);
      do_write(26'h004, 2'b11, 32'hA5A5_A5A5);
      do_read("clr_b4", 26'h004, 2'b01, 32'h0000_00A5);
      do_read("clr_oor", 26'h040, 2'b11, 32'hFFFF_FFFF);
`else
      @(negedge clk);
      chk("rst_rd_valid", {31'b0, mem_rd_valid}, 32'd0);
      chk("rst_rd_data", mem_rd_data, 32'd0);
      chk("rst_rd_ready", {31'b0, mem_rd_ready}, 32'd1);
      chk("rst_wr_ready", {31'b0, mem_wr_ready}, 32'd1);
      @(posedge clk); #1;

      do_write(26'h100, 2'b11, 32'hDEAD_BEEF);
      do_read("b100", 26'h100, 2'b01, 32'h0000_00EF);
      do_read("b101", 26'h101, 2'b01, 32'h0000_00BE);
      do_read("b102", 26'h102, 2'b01, 32'h0000_00AD);
      do_read("b103", 26'h103, 2'b01, 32'h0000_00DE);
      do_read("h101", 26'h101, 2'b10, 32'h0000_BEEF);

      do_write(26'h200, 2'b11, 32'h0000_0000);
      do_write(26'h202, 2'b10, 32'h0000_1234);
      do_read("w200", 26'h200, 2'b11, 32'h1234_0000);
      do_read("h203", 26'h203, 2'b10, 32'h0000_1234);

      // Concurrent read and write: write wins, read is held and taken next cycle.
      mem_wr = 1'b1; mem_rd = 1'b1; mem_addr = 26'h040;
      mem_data_width = 2'b01; mem_wr_data = 32'h0000_0055;
      @(negedge clk);
      chk("simul_rd_ready", {31'b0, mem_rd_ready}, 32'd0);
      chk("simul_wr_ready", {31'b0, mem_wr_ready}, 32'd1);
      @(posedge clk); #1;
      mem_wr = 1'b0;
      @(negedge clk);
      chk("simul_rd_ready2", {31'b0, mem_rd_ready}, 32'd1);
      @(posedge clk); #1;
      mem_rd = 1'b0;
      chk("simul_model", model_read(26'h040, 2'b01), 32'h0000_0055);
      wait_valid("simul_b40", 32'h0000_0055);

      do_write(26'(DEPTH * 4), 2'b11, 32'h1234_5678);
      do_read("oor_w", 26'(DEPTH * 4), 2'b11, 32'hFFFF_FFFF);
      do_read("oor_b", 26'(DEPTH * 4), 2'b01, 32'h0000_00FF);
      do_read("oor_h", 26'(DEPTH * 4 + 2), 2'b10, 32'h0000_FFFF);
      do_read("w0_rd", 26'h100, 2'b00, 32'hFFFF_FFFF);
      do_write(26'h100, 2'b00, 32'h0000_0000);
      do_write(26'h103, 2'b01, 32'h0000_0077);
      do_read("w100", 26'h100, 2'b11, 32'h77AD_BEEF);

      // Reset during RD_MEM drops the pending read; RAM is retained.
      mem_rd = 1'b1; mem_addr = 26'h100; mem_data_width = 2'b11;
      @(negedge clk);
      chk("rstrd_acc", {31'b0, mem_rd_ready}, 32'd1);
      @(posedge clk); #1;
      mem_rd = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      vcount = 0;
      @(negedge clk);
      chk("rstrd_ready", {31'b0, mem_rd_ready}, 32'd1);
      chk("rstrd_data", mem_rd_data, 32'd0);
      repeat (4) begin
         if (mem_rd_valid) vcount++;
         @(negedge clk);
      end
      chk("rstrd_no_valid", 32'(vcount), 32'd0);
      @(posedge clk); #1;
      do_read("post_rst", 26'h100, 2'b11, 32'h77AD_BEEF);
`endif
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
